// File: rtl/ivnormalizer.sv
// ivnormalizer: 2-stage packed-SIMD bit-scan unit (per-lane clz/ctz/cpop) with valid/ready, flush and tag.
// Define IVNORMALIZER_CPOP_EN to build the popcount path; without it op=10 behaves as reserved.
module ivnormalizer #(
   parameter int TAG_W = 6
) (
   input  logic             cpu_clock_i,
   input  logic             cpu_resetn_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [31:0]      a_i,
   input  logic             size_i,
   input  logic [1:0]       op_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [31:0]      c_o,
   output logic [TAG_W-1:0] tag_o
);

   typedef enum logic [1:0] {
      OP_CLZ  = 2'b00,
      OP_CTZ  = 2'b01,
      OP_CPOP = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   function automatic logic [3:0] lz8(input logic [7:0] b);
      logic [3:0] cnt;
      cnt = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) cnt = 4'(7 - i);
      end
      return cnt;
   endfunction

   function automatic logic [3:0] tz8(input logic [7:0] b);
      logic [3:0] cnt;
      cnt = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         if (b[i]) cnt = 4'(i);
      end
      return cnt;
   endfunction

`ifdef IVNORMALIZER_CPOP_EN
   function automatic logic [3:0] pc8(input logic [7:0] b);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b0, b[i]};
      end
      return cnt;
   endfunction
`endif

   logic                 s1_valid;
   logic [3:0][3:0]      s1_lz;
   logic [3:0][3:0]      s1_tz;
   logic [3:0]           s1_z;
   logic                 s1_size;
   op_e                  s1_op;
   logic [TAG_W-1:0]     s1_tag;
   logic [3:0][3:0]      lz_d;
   logic [3:0][3:0]      tz_d;
   logic [3:0]           z_d;
   logic [31:0]          c_next;
`ifdef IVNORMALIZER_CPOP_EN
   logic [3:0][3:0]      s1_pc;
   logic [3:0][3:0]      pc_d;
`endif

   logic s2_ready;
   logic accept;
   logic advance;

   assign s2_ready = !valid_o || ready_i;
   assign ready_o  = !s1_valid || s2_ready;
   assign accept   = valid_i && ready_o && !flush_i;
   assign advance  = s1_valid && s2_ready && !flush_i;

   // Per-byte scans feed stage 1; halfword results are assembled from these in stage 2.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lz_d[k] = lz8(a_i[8*k +: 8]);
         tz_d[k] = tz8(a_i[8*k +: 8]);
         z_d[k]  = (a_i[8*k +: 8] == 8'h00);
`ifdef IVNORMALIZER_CPOP_EN
         pc_d[k] = pc8(a_i[8*k +: 8]);
`endif
      end
   end

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin : combine
      logic [4:0] hw;
      c_next = '0;
      hw     = '0;
      if (!s1_size) begin
         for (int k = 0; k < 4; k++) begin
            case (s1_op)
               OP_CLZ:  c_next[8*k +: 8] = {4'b0, s1_lz[k]};
               OP_CTZ:  c_next[8*k +: 8] = {4'b0, s1_tz[k]};
`ifdef IVNORMALIZER_CPOP_EN
               OP_CPOP: c_next[8*k +: 8] = {4'b0, s1_pc[k]};
`endif
               default: c_next[8*k +: 8] = 8'h00;
            endcase
         end
      end else begin
         for (int h = 0; h < 2; h++) begin
            hw = '0;
            case (s1_op)
               OP_CLZ:  hw = s1_z[2*h+1] ? 5'd8 + {1'b0, s1_lz[2*h]}   : {1'b0, s1_lz[2*h+1]};
               OP_CTZ:  hw = s1_z[2*h]   ? 5'd8 + {1'b0, s1_tz[2*h+1]} : {1'b0, s1_tz[2*h]};
`ifdef IVNORMALIZER_CPOP_EN
               OP_CPOP: hw = {1'b0, s1_pc[2*h]} + {1'b0, s1_pc[2*h+1]};
`endif
               default: hw = '0;
            endcase
            c_next[16*h +: 16] = {11'b0, hw};
         end
      end
   end

   // NOTE: reset clears the data registers as well as the valid bits so c_o/tag_o read 0 after reset.
   always_ff @(posedge cpu_clock_i) begin
      if (!cpu_resetn_i) begin
         s1_valid <= 1'b0;
         s1_lz    <= '0;
         s1_tz    <= '0;
         s1_z     <= '0;
         s1_size  <= 1'b0;
         s1_op    <= OP_CLZ;
         s1_tag   <= '0;
`ifdef IVNORMALIZER_CPOP_EN
         s1_pc    <= '0;
`endif
         valid_o  <= 1'b0;
         c_o      <= '0;
         tag_o    <= '0;
      end else begin
         // Flush wins over any accept or advance in the same cycle.
         if (flush_i)      s1_valid <= 1'b0;
         else if (accept)  s1_valid <= 1'b1;
         else if (advance) s1_valid <= 1'b0;

         if (accept) begin
            s1_lz   <= lz_d;
            s1_tz   <= tz_d;
            s1_z    <= z_d;
            s1_size <= size_i;
            s1_op   <= op_e'(op_i);
            s1_tag  <= tag_i;
`ifdef IVNORMALIZER_CPOP_EN
            s1_pc   <= pc_d;
`endif
         end

         if (flush_i)      valid_o <= 1'b0;
         else if (advance) valid_o <= 1'b1;
         else if (ready_i) valid_o <= 1'b0;

         if (advance) begin
            c_o   <= c_next;
            tag_o <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_ivnormalizer.sv
// tb_ivnormalizer: directed vectors with a scoreboard queue; a negedge monitor pops and compares results.
// Expected popcount values follow IVNORMALIZER_CPOP_EN exactly as the design build does.
module tb_ivnormalizer;
   localparam int TAG_W = 6;
   localparam logic [1:0] CLZ = 2'b00, CTZ = 2'b01, CPOP = 2'b10, RSVD = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush_i;
   logic             valid_i;
   logic             ready_o;
   logic [31:0]      a_i;
   logic             size_i;
   logic [1:0]       op_i;
   logic [TAG_W-1:0] tag_i;
   logic             valid_o;
   logic             ready_i;
   logic [31:0]      c_o;
   logic [TAG_W-1:0] tag_o;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      c;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   out_cnt   = 0;
   int   base;

   ivnormalizer #(.TAG_W(TAG_W)) dut (
      .cpu_clock_i (clk),
      .cpu_resetn_i(rst_n),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .a_i         (a_i),
      .size_i      (size_i),
      .op_i        (op_i),
      .tag_i       (tag_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .c_o         (c_o),
      .tag_o       (tag_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] cp(input logic [31:0] v);
`ifdef IVNORMALIZER_CPOP_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   // ready_i only changes just after a posedge, so this sample matches what the next edge sees.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL spurious_output: tag %0d c %h appeared, required no output", tag_o, c_o);
         end else begin
            mon_e = sb.pop_front();
            check("out_c", c_o, mon_e.c);
            check("out_tag", 32'(tag_o), 32'(mon_e.tag));
            out_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic sz, input logic [1:0] op,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp);
      exp_t e;
      int   budget;
      @(negedge clk);
      valid_i = 1'b1; a_i = a; size_i = sz; op_i = op; tag_i = tag;
      #1;
      budget = 0;
      while (ready_o !== 1'b1 && budget < 50) begin
         @(negedge clk); #1;
         budget++;
      end
      if (ready_o !== 1'b1) begin
         total_cnt++;
         $display("FAIL send_timeout tag %0d: ready_o %b, required 1", tag, ready_o);
         valid_i = 1'b0;
         return;
      end
      e.tag = tag;
      e.c   = exp;
      sb.push_back(e);
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 100) begin
         @(negedge clk); #1;
         budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk); #1;
      ready_i = r;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      a_i = '0; size_i = 1'b0; op_i = CLZ; tag_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_valid_o", 32'(valid_o), 32'd0);
      check("rst_c_o", c_o, 32'h0);
      check("rst_tag_o", 32'(tag_o), 32'd0);
      check("rst_ready_o", 32'(ready_o), 32'd1);
      rst_n = 1'b1;

      // First op: two-cycle latency from an empty pipeline.
      send(32'h8040_0100, 1'b0, CLZ, 6'd1, 32'h0001_0708);
      @(negedge clk); #1;
      check("lat_edge_n", 32'(valid_o), 32'd0);
      @(negedge clk); #1;
      check("lat_edge_n1", 32'(valid_o), 32'd1);

      send(32'h0000_0100, 1'b1, CTZ,  6'd2,  32'h0010_0008);
      send(32'h0000_0000, 1'b1, CTZ,  6'd3,  32'h0010_0010);
      send(32'hFF0F_0301, 1'b0, CPOP, 6'd4,  cp(32'h0804_0201));
      send(32'h8001_FF00, 1'b0, CTZ,  6'd5,  32'h0700_0008);
      send(32'h0001_8000, 1'b1, CLZ,  6'd6,  32'h000F_0000);
      send(32'hFFFF_0F0F, 1'b1, CPOP, 6'd7,  cp(32'h0010_0008));
      send(32'hFFFF_FFFF, 1'b0, RSVD, 6'd8,  32'h0000_0000);
      send(32'hFFFF_FFFF, 1'b0, CPOP, 6'd9,  cp(32'h0808_0808));
      send(32'h0000_0000, 1'b1, CLZ,  6'd14, 32'h0010_0010);
      send(32'h0000_0000, 1'b0, CLZ,  6'd15, 32'h0808_0808);
      drain();

      // Back-to-back burst: four results on four consecutive cycles.
      base = out_cnt;
      send(32'h8000_0001, 1'b1, CPOP, 6'd10, cp(32'h0001_0001));
      send(32'h0102_0408, 1'b0, CTZ,  6'd11, 32'h0001_0203);
      send(32'h0102_0408, 1'b0, CLZ,  6'd12, 32'h0706_0504);
      send(32'h8000_0000, 1'b1, CTZ,  6'd13, 32'h000F_0010);
      @(posedge clk);
      @(negedge clk); #1;
      check("burst_consecutive", 32'(out_cnt - base), 32'd4);
      drain();

      // Stall: both stages fill, ready_o drops, held result stays put.
      set_ready(1'b0);
      send(32'h0102_0408, 1'b0, CLZ, 6'd20, 32'h0706_0504);
      send(32'h0000_0100, 1'b1, CTZ, 6'd21, 32'h0010_0008);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("stall_ready_o", 32'(ready_o), 32'd0);
         check("stall_valid_o", 32'(valid_o), 32'd1);
         check("stall_c_o", c_o, 32'h0706_0504);
         check("stall_tag_o", 32'(tag_o), 32'd20);
      end
      set_ready(1'b1);
      drain();

      // Flush with both stages full and a new op presented.
      set_ready(1'b0);
      send(32'h0102_0408, 1'b0, CLZ, 6'd30, 32'h0706_0504);
      send(32'h0102_0408, 1'b0, CTZ, 6'd31, 32'h0001_0203);
      @(negedge clk);
      valid_i = 1'b1; a_i = 32'h1234_5678; size_i = 1'b0; op_i = CLZ; tag_i = 6'd32; flush_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      sb.delete();
      @(negedge clk); #1;
      check("flush_full_valid_o", 32'(valid_o), 32'd0);
      check("flush_full_ready_o", 32'(ready_o), 32'd1);

      // Flush into an empty pipeline drops the op even though ready_o is high.
      @(negedge clk);
      valid_i = 1'b1; a_i = 32'h0000_0001; size_i = 1'b0; op_i = CTZ; tag_i = 6'd33; flush_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk); #1;
      check("flush_empty_valid_n", 32'(valid_o), 32'd0);
      @(negedge clk); #1;
      check("flush_empty_valid_n1", 32'(valid_o), 32'd0);
      set_ready(1'b1);
      send(32'h8000_0000, 1'b1, CTZ, 6'd34, 32'h000F_0010);
      drain();

      // Reset mid-stream with a held result on the output.
      set_ready(1'b0);
      send(32'h8040_0100, 1'b0, CLZ, 6'd40, 32'h0001_0708);
      send(32'h0000_0100, 1'b1, CTZ, 6'd41, 32'h0010_0008);
      @(negedge clk); #1;
      check("pre_reset_c_o", c_o, 32'h0001_0708);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_i = 1'b1;
      sb.delete();
      @(negedge clk); #1;
      check("mid_rst_valid_o", 32'(valid_o), 32'd0);
      check("mid_rst_c_o", c_o, 32'h0);
      check("mid_rst_tag_o", 32'(tag_o), 32'd0);
      check("mid_rst_ready_o", 32'(ready_o), 32'd1);
      send(32'h0001_8000, 1'b1, CLZ, 6'd42, 32'h000F_0000);
      @(negedge clk); #1;
      check("post_rst_lat_n", 32'(valid_o), 32'd0);
      @(negedge clk); #1;
      check("post_rst_lat_n1", 32'(valid_o), 32'd1);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/ivnormalizer.md
Name: ivnormalizer

Overview:
- Packed-SIMD bit-scan unit in the math system; the inverse companion of the vector shifter.
- The shifter consumes per-lane shift amounts. This block produces them: per-lane leading-zero, trailing-zero and (optionally) population counts.
- Lane format matches the shifter's: size=0 gives 4x8-bit lanes, size=1 gives 2x16-bit lanes.
- 2-stage pipeline with valid/ready on both sides, a flush input and a tag passthrough, so it slots into the integer issue path beside the shifter.

Parameters:
- TAG_W, 6, width of the passthrough tag (ROB index).

Ports:
- cpu_clock_i  in  1  clock
- cpu_resetn_i  in  1  synchronous reset, active low
- flush_i  in  1  kill all in-flight ops
- valid_i  in  1  op presented
- ready_o  out  1  block accepts op this cycle
- a_i  in  32  source operand
- size_i  in  1  0 = 8-bit lanes, 1 = 16-bit lanes
- op_i  in  2  00 clz, 01 ctz, 10 cpop, 11 reserved
- tag_i  in  TAG_W  passthrough tag
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- c_o  out  32  packed per-lane counts
- tag_o  out  TAG_W  tag of result

Behaviour:
- Reset (cpu_resetn_i=0 at posedge): s1_valid=0, s2_valid=0, valid_o=0, c_o=0, tag_o=0. ready_o follows its equation and is therefore 1 during reset.
- Handshake: an input transfers when valid_i&ready_o; an output transfers when valid_o&ready_i.
  - ready_o = !s1_valid | (!s2_valid | ready_i).
  - Stage 1 advances into stage 2 when s1_valid & (!s2_valid | ready_i).
  - Full throughput: 1 op/cycle when ready_i is held high.
- Latency: 2 cycles. An op accepted at edge N appears at valid_o after edge N+1; held-in result is unchanged while ready_i=0.
- Stage 1, per byte k=0..3 of a_i (registered along with size, op, tag):
  - lz[k] = leading zeros 0..8
  - tz[k] = trailing zeros 0..8
  - pc[k] = popcount 0..8
  - z[k] = byte all zero
- Stage 2 combine, registered into c_o.
  - size=0: byte k of c_o = {4'b0, count[k]} for the selected op.
  - size=1, halfword h uses bytes lo=2h and hi=2h+1:
    - clz = z[hi] ? 8+lz[lo] : lz[hi]
    - ctz = z[lo] ? 8+tz[hi] : tz[lo]
    - cpop = pc[lo]+pc[hi]
    - Result is zero-extended to 16 bits.
- op=11: result lanes are all 0; the op still completes with valid_o and its tag.
- Boundaries:
  - All-zero lane gives clz = ctz = lane width (8 or 16).
  - All-ones lane gives cpop = lane width.
  - Results never exceed 5 bits, and upper lane bits are always 0.
- Flush: on a posedge with flush_i=1, s1_valid and s2_valid clear.
  - Any input presented that cycle is dropped, even if ready_o=1.
  - valid_o=0 on the next cycle.
  - Flush has priority over a simultaneous accept or advance.
- Reset mid-operation behaves as flush, plus clears the data registers.
- Stalled output with a new input: stage 1 fills. ready_o drops only when both stages hold ops and ready_i=0.

Optional Feature:
- Macro IVNORMALIZER_CPOP_EN.
- Defined: op=10 computes popcount as above.
- Undefined: the pc[] logic and its adder are omitted. op=10 is treated as reserved: result 0, still handshaken with its tag.

Test Plan:
- size=0, op=clz, a=32'h8040_0100 -> c_o=32'h0001_0708 after 2 cycles, tag echoed.
- size=1, op=ctz, a=32'h0000_0100 -> c_o=32'h0010_0008; a=32'h0 -> 32'h0010_0010.
- size=0, op=cpop, a=32'hFF0F_0301 (CPOP_EN defined) -> c_o=32'h0804_0201; same stimulus with the macro undefined -> 32'h0.
- Back-to-back 4 ops with ready_i=1 -> 4 results on 4 consecutive cycles, in order. Then hold ready_i=0 for 3 cycles: ready_o=0 once both stages are full, and c_o/tag_o stay stable.
- Assert flush_i with both stages full and valid_i=1 -> valid_o=0 next cycle; the flushed tags never appear.
- Pulse cpu_resetn_i=0 mid-stream -> valid_o=0, c_o=0 next cycle; the first op after release completes with the normal 2-cycle latency.
